// File: rtl/bus_timer_if.sv
// Processor bus connecting one initiator to one responder.
// Carries a single-outstanding valid/ready handshake plus a level interrupt.
interface Bus;
    logic        valid;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrobe;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    modport m (output valid, address, wdata, wstrobe, input rdata, ready, irq);
    modport s (input valid, address, wdata, wstrobe, output rdata, ready, irq);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped interval timer on the Bus responder port: CONTROL/LIMIT/COUNT/STATUS
// registers, programmable wait states, prescaled counter and a registered interrupt.
module bus_timer #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PRESCALER   = 1
) (
    input logic clk,
    input logic reset,
    Bus.s       bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

    localparam int unsigned      PSC_W     = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX   = PSC_W'(PRESCALER - 1);
    localparam logic [3:0]       WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] A_CONTROL = 2'd0;
    localparam logic [1:0] A_LIMIT   = 2'd1;
    localparam logic [1:0] A_COUNT   = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    state_e             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [1:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [2:0]         ctrl_q, ctrl_d;      // {auto_reload, irq_enable, enable}
    logic [31:0]        limit_q, limit_d;
    logic [31:0]        count_q, count_d;
    logic               event_q, event_d;
    logic               irq_q, irq_d;
    logic [PSC_W-1:0]   psc_q, psc_d;

    logic [1:0]  rd_sel;
    logic [31:0] rd_val;
    logic        commit, wr_ctrl, wr_limit, wr_count, clr_event;
    logic        tick, hit;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.address[31:4], bus.address[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin : fsm_comb
        // NOTE: every combinational output gets its default first so no path can infer a latch.
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid) begin
                    addr_d  = bus.address[3:2];
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrobe;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        wait_d  = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) state_d = ST_ACK;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The zero-wait path enters ACK straight from IDLE, before the address is captured.
        rd_sel = (state_q == ST_IDLE) ? bus.address[3:2] : addr_q;
        case (rd_sel)
            A_CONTROL: rd_val = {29'd0, ctrl_q};
            A_LIMIT:   rd_val = limit_q;
            A_COUNT:   rd_val = count_q;
            default:   rd_val = {31'd0, event_q};
        endcase
        rdata_d = (state_d == ST_ACK && state_q != ST_ACK) ? rd_val : rdata_q;
    end

    always_comb begin : timer_comb
        commit    = (state_q == ST_ACK);
        wr_ctrl   = commit && addr_q == A_CONTROL && wstrb_q[0];
        wr_limit  = commit && addr_q == A_LIMIT   && (|wstrb_q);
        wr_count  = commit && addr_q == A_COUNT   && (|wstrb_q);
        clr_event = commit && addr_q == A_STATUS  && wstrb_q[0] && wdata_q[0];

        tick  = ctrl_q[0] && (psc_q == PSC_MAX);
        hit   = tick && (count_q == limit_q);
        psc_d = (!ctrl_q[0] || tick) ? '0 : psc_q + 1'b1;

        ctrl_d  = ctrl_q;
        count_d = count_q;
        if (tick) begin
            if (!hit)           count_d   = count_q + 32'd1;
            else if (ctrl_q[2]) count_d   = 32'd0;
            else                ctrl_d[0] = 1'b0;
        end
        // Bus writes are applied last so they override the tick's update.
        if (wr_ctrl)  ctrl_d  = wdata_q[2:0];
        if (wr_count) count_d = merge_bytes(count_q, wdata_q, wstrb_q);
        limit_d = wr_limit ? merge_bytes(limit_q, wdata_q, wstrb_q) : limit_q;

        event_d = hit | (event_q & ~clr_event);
        irq_d   = event_q & ctrl_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            ctrl_q  <= '0;
            limit_q <= '0;
            count_q <= '0;
            event_q <= 1'b0;
            irq_q   <= 1'b0;
            psc_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            limit_q <= limit_d;
            count_q <= count_d;
            event_q <= event_d;
            irq_q   <= irq_d;
            psc_q   <= psc_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = (state_q == ST_ACK);
    assign bus.irq   = irq_q;

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped interval timer acting as a responder (target) on the processor's `Bus` interface; it is the other end of the CPU's initiator port.
- Decodes four 32-bit registers and answers each transfer with a configurable number of wait states.
- Counts cycles through a prescaler and raises `bus.irq` when the count reaches a programmed limit.
- Sits behind the bus interconnect, which routes to it only the transfers in its address window.

Parameters:
- WAIT_STATES, 0, extra cycles inserted between transfer acceptance and `ready` (0..15).
- PRESCALER, 1, clock cycles per count increment (>=1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bus  Bus.s  -  responder modport. Members:
  - valid  in  1
  - address  in  32  only [3:2] decoded
  - wdata  in  32
  - wstrobe  in  4  byte enables; all zero means read
  - rdata  out  32
  - ready  out  1
  - irq  out  1

Behaviour:
- Register map (address[3:2]):
  - 0 CONTROL: bit0 enable, bit1 irq_enable, bit2 auto_reload; bits [31:3] read 0.
  - 1 LIMIT: 32 bits.
  - 2 COUNT: 32 bits.
  - 3 STATUS: bit0 event; write 1 to clear.
- Reset values: all registers 0; `rdata`=0, `ready`=0, `irq`=0; handshake state=IDLE; prescaler counter=0.
- Handshake FSM, states IDLE, WAIT, ACK:
  - IDLE: if `valid`, capture `address[3:2]`, `wdata` and `wstrobe`. Go to ACK if WAIT_STATES=0, else load the wait counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement each cycle; go to ACK when the counter is 0. `valid` is not re-sampled.
  - ACK: `ready`=1 for exactly one cycle, then IDLE.
- Latency: `ready` is high WAIT_STATES+1 cycles after the first cycle `valid` is seen in IDLE. Minimum period between two acknowledged transfers is WAIT_STATES+2 cycles, because IDLE lasts at least one cycle.
- `rdata` is registered. It is loaded on the edge entering ACK with the selected register value at that edge and is held until the next load. `rdata` is also loaded for writes and the initiator ignores it.
- Writes commit on the edge that ends ACK, byte lane i only where `wstrobe[i]`=1:
  - CONTROL: only byte 0 bits [2:0] are writable.
  - STATUS: clears bit0 when `wstrobe[0]`=1 and `wdata[0]`=1.
- Counter, when enable=1:
  - The prescaler counts 0..PRESCALER-1; each wrap is a tick.
  - On a tick: if COUNT==LIMIT, set STATUS.event. Then, if auto_reload=1, COUNT<=0; otherwise COUNT holds and enable<=0. If COUNT!=LIMIT, COUNT<=COUNT+1 with 32-bit wrap.
  - LIMIT=0 with auto_reload produces an event every tick.
  - enable=0 freezes COUNT and resets the prescaler to 0.
- Simultaneous events:
  - A bus write to COUNT or CONTROL in the same cycle as a tick wins over the tick's update of that register.
  - An event set wins over a STATUS write-1-to-clear in the same cycle.
- `irq` is registered: `irq` <= STATUS.event & irq_enable, so it follows the flag by one cycle. The flag is level-based and stays asserted until cleared.
- Reset asserted mid-transfer (WAIT or ACK) aborts the transfer: no write commits, `ready`=0 on the following cycle, FSM=IDLE.

Test Plan:
- Reset with WAIT_STATES=0 -> `ready`=0, `irq`=0, `rdata`=0; read of each of the 4 registers returns 0 with `ready` exactly 1 cycle after `valid`.
- WAIT_STATES=3: write LIMIT=0x12345678 (`wstrobe`=4'b1111), then read LIMIT -> `ready` 4 cycles after `valid` each time; read returns 0x12345678. Then write `wstrobe`=4'b0010 with `wdata`=0xAAAAAAAA -> LIMIT=0x1234AA78.
- PRESCALER=1: LIMIT=3, CONTROL=0b111 -> COUNT sequence 1,2,3,0,1...; STATUS.event set on the tick where COUNT==3; `irq`=1 one cycle later; write STATUS=1 -> `irq` drops one cycle after commit.
- One-shot mode: LIMIT=2, CONTROL=0b001 -> COUNT stops at 2; CONTROL reads 0b000 afterwards; `irq` stays 0 because irq_enable=0 while STATUS.event=1.
- Collision cases:
  - Write COUNT=0x100 on the same edge as a tick -> COUNT reads 0x100.
  - STATUS clear on the same edge as an event -> event stays 1.
- PRESCALER=4 -> COUNT increments once every 4 cycles.
- Reset pulsed during WAIT of a write to LIMIT (WAIT_STATES=5) -> LIMIT remains 0, no `ready` pulse; the next transfer completes normally.
